// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared types and defaults for the IFU/LSU memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, WAIT)
//   gnt_t   : requester identity (GNT_IFU, GNT_LSU)
//   DEF_*   : default address/data widths and IFU read byte mask
package npc_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {GNT_IFU, GNT_LSU} gnt_t;

    localparam int         DEF_ADDR_W   = 32;
    localparam int         DEF_DATA_W   = 32;
    localparam logic [7:0] DEF_IFU_MASK = 8'h0F;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   ifu_valid, lsu_valid : request valids
//   last_gnt             : requester granted most recently
//   gnt                  : one-hot grant, bit 0 = IFU, bit 1 = LSU
//   any                  : at least one requester is valid
module rr_arb2
    import npc_mem_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  gnt_t       last_gnt,
    output logic [1:0] gnt,
    output logic       any
);

    // On a tie the requester that did not win last time goes first.
    assign gnt[0] = ifu_valid && (!lsu_valid || last_gnt == GNT_LSU);
    assign gnt[1] = lsu_valid && (!ifu_valid || last_gnt == GNT_IFU);
    assign any    = ifu_valid || lsu_valid;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU and LSU, one
// transaction at a time, round-robin on ties.
//   clk, rst (async, active-low)
//   ifu_*  : IFU read request / ready handshake and rvalid/rdata response
//   lsu_*  : LSU load/store request / ready handshake and rvalid/rdata response
//   mem_*  : downstream request (registered fields) and response
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int         ADDR_W   = DEF_ADDR_W,
    parameter int         DATA_W   = DEF_DATA_W,
    parameter logic [7:0] IFU_MASK = DEF_IFU_MASK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_mask,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_mask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t     state, state_n;
    gnt_t       last_gnt, owner;
    logic [1:0] gnt;
    logic       any;
    logic       resp;

    rr_arb2 u_arb (
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .last_gnt  (last_gnt),
        .gnt       (gnt),
        .any       (any)
    );

    always_comb begin
        state_n       = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        resp          = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = gnt[0];
                lsu_req_ready = gnt[1];
                state_n       = any ? REQ : IDLE;
            end
            REQ:  state_n = mem_req_ready ? WAIT : REQ;
            WAIT: begin
                resp    = mem_rvalid;
                state_n = mem_rvalid ? IDLE : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_gnt      <= GNT_LSU;
            owner         <= GNT_IFU;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_mask      <= '0;
            ifu_rvalid    <= 1'b0;
            lsu_rvalid    <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rdata     <= '0;
        end else begin
            state         <= state_n;
            mem_req_valid <= (state_n == REQ);
            ifu_rvalid    <= resp && owner == GNT_IFU;
            lsu_rvalid    <= resp && owner == GNT_LSU;
            if (state == IDLE && any) begin
                owner     <= gnt[0] ? GNT_IFU : GNT_LSU;
                last_gnt  <= gnt[0] ? GNT_IFU : GNT_LSU;
                mem_addr  <= gnt[0] ? ifu_addr : lsu_addr;
                mem_we    <= gnt[0] ? 1'b0 : lsu_we;
                mem_wdata <= gnt[0] ? '0 : lsu_wdata;
                mem_mask  <= gnt[0] ? IFU_MASK : lsu_mask;
            end
            if (resp && owner == GNT_IFU)
                ifu_rdata <= mem_rdata;
            if (resp && owner == GNT_LSU)
                lsu_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (round-robin winner, captured
// request fields, response routing and rdata retention).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rvalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_mask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;

    int checks = 0;
    int errors = 0;

    bit          last_i;
    logic [31:0] m_ifu_rdata, m_lsu_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mask", mem_mask, 0);
        chk("rst_ifu_rvalid", ifu_rvalid, 0);
        chk("rst_lsu_rvalid", lsu_rvalid, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling
    // edge of the cycle in which the owner's rvalid is expected.
    task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input bit we,
                       input logic [31:0] la, input logic [31:0] wd, input logic [7:0] mk,
                       input int rdy, input int rvd, input bit spur, input bit hold,
                       input logic [31:0] rd);
        bit          win_i;
        logic [31:0] ea, ewd;
        logic [7:0]  em;
        bit          ewe;
        win_i  = (iv && lv) ? !last_i : iv;
        last_i = win_i;
        ea  = win_i ? ia : la;
        ewe = win_i ? 1'b0 : we;
        ewd = win_i ? 32'h0 : wd;
        em  = win_i ? 8'h0F : mk;
        ifu_req_valid = iv;  ifu_addr  = ia;
        lsu_req_valid = lv;  lsu_we    = we;  lsu_addr = la;
        lsu_wdata     = wd;  lsu_mask  = mk;
        #1;
        chk("ifu_req_ready", ifu_req_ready, win_i);
        chk("lsu_req_ready", lsu_req_ready, !win_i);
        @(posedge clk); #1;
        if (!hold) begin
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end
        for (int i = 0; i <= rdy; i++) begin
            mem_rvalid = spur && i < rdy;
            mem_rdata  = $urandom;
            @(negedge clk);
            chk("req_mem_req_valid", mem_req_valid, 1);
            chk("req_mem_addr", mem_addr, ea);
            chk("req_mem_we", mem_we, ewe);
            chk("req_mem_wdata", mem_wdata, ewd);
            chk("req_mem_mask", mem_mask, em);
            chk("req_ifu_rvalid", ifu_rvalid, 0);
            chk("req_lsu_rvalid", lsu_rvalid, 0);
            chk("req_readies", {ifu_req_ready, lsu_req_ready}, 0);
            mem_req_ready = (i == rdy);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j <= rvd; j++) begin
            mem_rvalid = (j == rvd);
            mem_rdata  = (j == rvd) ? rd : $urandom;
            @(negedge clk);
            chk("wait_mem_req_valid", mem_req_valid, 0);
            chk("wait_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        if (win_i) m_ifu_rdata = rd;
        else       m_lsu_rdata = rd;
        @(negedge clk);
        chk("resp_ifu_rvalid", ifu_rvalid, win_i);
        chk("resp_lsu_rvalid", lsu_rvalid, !win_i);
        chk("resp_ifu_rdata", ifu_rdata, m_ifu_rdata);
        chk("resp_lsu_rdata", lsu_rdata, m_lsu_rdata);
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_mask = 0;
        mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        last_i = 1'b0;
        m_ifu_rdata = 0; m_lsu_rdata = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        chk("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Tie from reset goes to IFU, then alternation with both held valid.
        txn(1, 1, 32'h8000_0004, 0, 32'h8000_1000, 32'h0, 8'hFF, 0, 0, 0, 1, 32'h1111_0001);
        txn(1, 1, 32'h8000_0004, 0, 32'h8000_1000, 32'h0, 8'hFF, 0, 0, 0, 1, 32'h2222_0002);
        txn(1, 1, 32'h8000_0008, 0, 32'h8000_1004, 32'h0, 8'hFF, 0, 0, 0, 1, 32'h3333_0003);
        txn(1, 1, 32'h8000_000C, 0, 32'h8000_1008, 32'h0, 8'hFF, 0, 0, 0, 0, 32'h4444_0004);

        // IFU-only fetch with minimum latency.
        txn(1, 0, 32'h8000_0000, 0, 32'h0, 32'h0, 8'h0, 0, 0, 0, 0, 32'h0010_0093);

        // Store stalled by mem_req_ready for 4 cycles, spurious rvalid in REQ.
        txn(0, 1, 32'h0, 1, 32'h8000_2000, 32'hDEAD_BEEF, 8'h03, 4, 1, 1, 0, 32'h5555_AAAA);

        // Spurious rvalid in IDLE.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_spur_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
        chk("idle_spur_mem_req_valid", mem_req_valid, 0);
        chk("idle_spur_ifu_rdata", ifu_rdata, m_ifu_rdata);

        // Back-to-back: LSU request accepted in the IFU rvalid cycle.
        txn(1, 0, 32'h8000_0010, 0, 32'h0, 32'h0, 8'h0, 0, 0, 0, 0, 32'h0000_0013);
        txn(0, 1, 32'h0, 0, 32'h8000_3000, 32'h0, 8'h0F, 0, 0, 0, 0, 32'hCAFE_F00D);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            bit iv, lv;
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(iv, lv, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("gap_readies", {ifu_req_ready, lsu_req_ready}, 0);
                chk("gap_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
            end
        end

        // Reset while waiting for the memory response.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        last_i = 1'b0;
        m_ifu_rdata = 0;
        m_lsu_rdata = 0;
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
        chk("post_rst_mem_req_valid", mem_req_valid, 0);
        txn(1, 1, 32'h8000_0044, 0, 32'h8000_4000, 32'h0, 8'hF0, 1, 2, 0, 0, 32'h0040_0113);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter and transaction sequencer between the NPC instruction fetch unit (IFU) and load/store unit (LSU), and the single shared memory port. It accepts one request at a time, grants by two-way round-robin, drives the downstream request handshake, waits for the memory response, and returns it to the owning requester. It replaces the direct per-unit `pmem_read`/`pmem_write` paths once the core fetches and accesses data through one port.

## Interface

- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `IFU_MASK`, 8'h0F, byte mask driven on IFU reads

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `ifu_req_valid`  in  1  IFU read request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_addr`  in  ADDR_W  fetch address
- `ifu_rvalid`  out  1  one-cycle IFU response pulse
- `ifu_rdata`  out  DATA_W  fetched instruction, valid with `ifu_rvalid`
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_addr`  in  ADDR_W  access address
- `lsu_wdata`  in  DATA_W  store data
- `lsu_mask`  in  8  byte mask (read or write)
- `lsu_rvalid`  out  1  one-cycle completion pulse (loads and stores)
- `lsu_rdata`  out  DATA_W  load data; don't-care for stores
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream accepts request
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_mask`  out  1/ADDR_W/DATA_W/8  captured request fields
- `mem_rvalid`  in  1  downstream response
- `mem_rdata`  in  DATA_W  downstream read data

## Operation

- FSM states: IDLE, REQ, WAIT.
- IDLE: pick the winner among the valid requesters. If exactly one is valid, it wins. If both are valid, the winner is the opposite of `last_gnt`. Assert the winner's `*_req_ready` combinationally (the loser's ready stays 0). At the edge, capture addr, we, wdata and mask (IFU: we=0, wdata=0, mask=`IFU_MASK`), record the owner, update `last_gnt`, and go to REQ.
- REQ: `mem_req_valid`=1 with the captured fields held stable. On `mem_req_ready`=1 go to WAIT. `mem_rvalid` is ignored in REQ.
- WAIT: `mem_req_valid`=0. On `mem_rvalid`=1, register `mem_rdata` into the owner's rdata, pulse the owner's rvalid for exactly one cycle, and go to IDLE.
- Both `*_req_ready` are 0 outside IDLE, so there is no second outstanding request.
- Responses have no backpressure; requesters always consume the rvalid pulse.
- `mem_rvalid` in IDLE or REQ is ignored with no state change.
- `*_rdata` hold their last value until the next response to that requester.

## Timing

- Reset (rst=0, async): state=IDLE, `last_gnt`=LSU (so the first tie goes to IFU). `mem_req_valid`, `mem_we`, `ifu_rvalid`, `lsu_rvalid`=0. `mem_addr`, `mem_wdata`, `ifu_rdata`, `lsu_rdata`=0. `mem_mask`=0.
- Reset mid-transaction drops the transaction; no rvalid is produced for it.
- Request handshake at edge T → `mem_req_valid`=1 from T+1. With `mem_req_ready`=1 at T+1 and `mem_rvalid`=1 at T+2, the owner's rvalid=1 during T+3. The minimum request-to-response latency is 3 cycles.
- The owner's rvalid cycle is an IDLE cycle, so a new request is accepted in that same cycle.
- All outputs except `*_req_ready` are registered.

## Structure

- Package `npc_mem_pkg`: state enum (IDLE/REQ/WAIT), grant enum (GNT_IFU/GNT_LSU), `IFU_MASK` default, `ADDR_W`/`DATA_W` defaults.
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs: two valids and `last_gnt`. Outputs: a one-hot grant and `any`. The FSM, capture registers, and response demux stay in `mem_arbiter`.

## Test plan

- IFU only, addr 0x8000_0000, mem ready immediate, rdata 0x0010_0093 one cycle later → `mem_mask`=0x0F, `mem_we`=0, `ifu_rvalid` 3 cycles after the handshake with rdata 0x0010_0093, `lsu_rvalid` stays 0.
- Both valid from reset, IFU 0x8000_0004, LSU load 0x8000_1000 → IFU served first, LSU next. With both held valid, grants alternate I,L,I,L over 4 transactions.
- LSU store addr 0x8000_2000, wdata 0xDEAD_BEEF, mask 0x03; `mem_req_ready` held 0 for 4 cycles → `mem_req_valid` and all fields stable for 5 cycles. `lsu_rvalid` pulses once after `mem_rvalid`.
- Spurious `mem_rvalid` in IDLE and in REQ → no rvalid output, state unchanged.
- rst=0 pulsed while in WAIT → outputs reach reset values immediately. A later `mem_rvalid` is ignored, and the next IFU request is served normally.
- Back-to-back: new LSU request asserted during the IFU rvalid cycle → accepted in that cycle, `mem_req_valid` on the next cycle.
